// File: rtl/dsp_seq_pkg.sv
// Shared types for the DSP mode sequencer: microinstruction layout, mode-field
// widths and FSM state encoding.
package dsp_seq_pkg;

  localparam int unsigned UCODE_W      = 20;
  localparam int unsigned ALUMODE_W    = 4;
  localparam int unsigned OPMODE_W     = 7;
  localparam int unsigned INMODE_W     = 5;
  localparam int unsigned CARRYINSEL_W = 3;

  localparam int unsigned ALUMODE_LSB    = 0;
  localparam int unsigned OPMODE_LSB     = 4;
  localparam int unsigned INMODE_LSB     = 11;
  localparam int unsigned CARRYINSEL_LSB = 16;
  localparam int unsigned LAST_BIT       = 19;

  localparam int unsigned DRAIN_W = 4;

  typedef struct packed {
    logic [CARRYINSEL_W-1:0] carryinsel;
    logic [INMODE_W-1:0]     inmode;
    logic [OPMODE_W-1:0]     opmode;
    logic [ALUMODE_W-1:0]    alumode;
  } mode_t;

  typedef struct packed {
    logic  last;
    mode_t mode;
  } ucode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  // A pass ends on an explicit LAST or when the final slot is reached.
  function automatic logic pass_ends(input ucode_t w, input logic last_slot);
    return w.last | last_slot;
  endfunction

endpackage

// File: rtl/dsp_seq_ucode_ram.sv
// Microinstruction store: DEPTH x 20 register file, synchronous write,
// asynchronous read. Contents are not reset.
module dsp_seq_ucode_ram
  import dsp_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  ucode_t        wdata,
  input  logic [AW-1:0] raddr,
  output ucode_t        rdata
);

  ucode_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dsp_mode_sequencer.sv
// Microcoded DSP-slice mode sequencer: replays the ucode table for REPS+1 passes,
// drains LATENCY cycles, then pulses DONE. Optional ABORT input via DSP_SEQ_ABORT_EN.
module dsp_mode_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CNTW    = 8,
  parameter int unsigned LATENCY = 4
) (
  input  logic                     CLK,
  input  logic                     RSTSEQ,
  input  logic                     WE,
  input  logic [$clog2(DEPTH)-1:0] WADDR,
  input  logic [UCODE_W-1:0]       WDATA,
  input  logic                     START,
  input  logic [CNTW-1:0]          REPS,
  input  logic                     STALL,
`ifdef DSP_SEQ_ABORT_EN
  input  logic                     ABORT,
`endif
  output logic [ALUMODE_W-1:0]     ALUMODE_OUT,
  output logic [OPMODE_W-1:0]      OPMODE_OUT,
  output logic [INMODE_W-1:0]      INMODE_OUT,
  output logic [CARRYINSEL_W-1:0]  CARRYINSEL_OUT,
  output logic                     CE_OUT,
  output logic                     BUSY,
  output logic                     DONE
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PC_MAX = AW'(DEPTH - 1);

  seq_state_t          state, state_nx;
  logic [AW-1:0]       pc, pc_nx;
  logic [CNTW-1:0]     pass_cnt, pass_nx;
  logic [DRAIN_W-1:0]  drain_cnt, drain_nx;
  mode_t               mode_q, mode_nx;
  logic                ce_q, ce_nx;
  logic                busy_q, busy_nx;
  logic                done_q, done_nx;
  logic                abort_req;
  logic                tbl_we;
  ucode_t              slot;

`ifdef DSP_SEQ_ABORT_EN
  assign abort_req = ABORT;
`else
  assign abort_req = 1'b0;
`endif

  assign tbl_we = WE && (state == ST_IDLE);

  dsp_seq_ucode_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (CLK),
    .we    (tbl_we),
    .waddr (WADDR),
    .wdata (ucode_t'(WDATA)),
    .raddr (pc),
    .rdata (slot)
  );

  // Status outputs describe the state the sequencer was in when the edge fired,
  // so BUSY/DONE lag the state register by one cycle like the mode outputs.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    pass_nx  = pass_cnt;
    drain_nx = drain_cnt;
    mode_nx  = mode_q;
    ce_nx    = 1'b0;
    busy_nx  = (state == ST_RUN) || (state == ST_DRAIN);
    done_nx  = (state == ST_DONE);

    unique case (state)
      ST_IDLE: begin
        if (START && !WE) begin
          state_nx = ST_RUN;
          pc_nx    = '0;
          pass_nx  = REPS;
        end
      end

      ST_RUN: begin
        if (abort_req) begin
          state_nx = ST_DONE;
        end else if (!STALL) begin
          mode_nx = slot.mode;
          ce_nx   = 1'b1;
          if (pass_ends(slot, pc == PC_MAX)) begin
            pc_nx = '0;
            if (pass_cnt == '0) begin
              state_nx = ST_DRAIN;
              drain_nx = DRAIN_W'(LATENCY);
            end else begin
              pass_nx = pass_cnt - CNTW'(1);
            end
          end else begin
            pc_nx = pc + AW'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (abort_req) begin
          state_nx = ST_DONE;
        end else if (!STALL) begin
          ce_nx    = 1'b1;
          drain_nx = drain_cnt - DRAIN_W'(1);
          if (drain_cnt == DRAIN_W'(1)) begin
            state_nx = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_nx = ST_IDLE;
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RSTSEQ) begin
      state     <= ST_IDLE;
      pc        <= '0;
      pass_cnt  <= '0;
      drain_cnt <= '0;
      mode_q    <= '0;
      ce_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      pass_cnt  <= pass_nx;
      drain_cnt <= drain_nx;
      mode_q    <= mode_nx;
      ce_q      <= ce_nx;
      busy_q    <= busy_nx;
      done_q    <= done_nx;
    end
  end

  assign ALUMODE_OUT    = mode_q.alumode;
  assign OPMODE_OUT     = mode_q.opmode;
  assign INMODE_OUT     = mode_q.inmode;
  assign CARRYINSEL_OUT = mode_q.carryinsel;
  assign CE_OUT         = ce_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;

endmodule

// File: tb/tb_dsp_mode_sequencer.sv
// Self-checking bench for dsp_mode_sequencer: vector table for the basic and
// stalled runs, a timing model for longer runs, scoreboard queue for outputs.
module tb_dsp_mode_sequencer;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned CNTW    = 8;
  localparam int unsigned LATENCY = 4;
  localparam int unsigned AW      = $clog2(DEPTH);

  logic            CLK = 1'b0;
  logic            RSTSEQ = 1'b1;
  logic            WE = 1'b0;
  logic [AW-1:0]   WADDR = '0;
  logic [19:0]     WDATA = '0;
  logic            START = 1'b0;
  logic [CNTW-1:0] REPS = '0;
  logic            STALL = 1'b0;
`ifdef DSP_SEQ_ABORT_EN
  logic            ABORT = 1'b0;
`endif
  logic [3:0]      ALUMODE_OUT;
  logic [6:0]      OPMODE_OUT;
  logic [4:0]      INMODE_OUT;
  logic [2:0]      CARRYINSEL_OUT;
  logic            CE_OUT, BUSY, DONE;

  dsp_mode_sequencer #(
    .DEPTH   (DEPTH),
    .CNTW    (CNTW),
    .LATENCY (LATENCY)
  ) dut (
    .CLK            (CLK),
    .RSTSEQ         (RSTSEQ),
    .WE             (WE),
    .WADDR          (WADDR),
    .WDATA          (WDATA),
    .START          (START),
    .REPS           (REPS),
    .STALL          (STALL),
`ifdef DSP_SEQ_ABORT_EN
    .ABORT          (ABORT),
`endif
    .ALUMODE_OUT    (ALUMODE_OUT),
    .OPMODE_OUT     (OPMODE_OUT),
    .INMODE_OUT     (INMODE_OUT),
    .CARRYINSEL_OUT (CARRYINSEL_OUT),
    .CE_OUT         (CE_OUT),
    .BUSY           (BUSY),
    .DONE           (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic            rst;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [19:0]     wdata;
    logic            start;
    logic [CNTW-1:0] reps;
    logic            stall;
    logic            abort;
    logic [18:0]     mode;
    logic            ce;
    logic            busy;
    logic            done;
  } vec_t;

  vec_t        exp_q[$];
  vec_t        tbl[28];
  logic [19:0] shadow[DEPTH];
  logic [18:0] last_mode;
  int          total = 0;
  int          bad = 0;
  int          step = 0;
  string       phase = "reset";

  function automatic vec_t mk(input logic rst, input logic we, input logic [AW-1:0] waddr,
                              input logic [19:0] wdata, input logic start,
                              input logic [CNTW-1:0] reps, input logic stall,
                              input logic abort, input logic [18:0] mode,
                              input logic ce, input logic busy, input logic done);
    vec_t v;
    v.rst = rst; v.we = we; v.waddr = waddr; v.wdata = wdata; v.start = start;
    v.reps = reps; v.stall = stall; v.abort = abort; v.mode = mode;
    v.ce = ce; v.busy = busy; v.done = done;
    return v;
  endfunction

  // Table row: START with REPS=1, optional STALL, expected outputs.
  function automatic vec_t row(input logic start, input logic stall, input logic [18:0] mode,
                               input logic ce, input logic busy, input logic done);
    return mk(1'b0, 1'b0, '0, '0, start, CNTW'(1), stall, 1'b0, mode, ce, busy, done);
  endfunction

  function automatic logic [19:0] mkw(input logic last, input logic [3:0] alu, input int unsigned i);
    return {last, 3'(i), 5'(i + 1), 7'(16 + i), alu};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s/%s step %0d: got %h want %h", phase, name, step, act, req);
    end
  endtask

  task automatic cyc(input vec_t v);
    vec_t e;
    @(negedge CLK);
    RSTSEQ = v.rst; WE = v.we; WADDR = v.waddr; WDATA = v.wdata;
    START = v.start; REPS = v.reps; STALL = v.stall;
`ifdef DSP_SEQ_ABORT_EN
    ABORT = v.abort;
`endif
    exp_q.push_back(v);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    step++;
    chk("mode", 32'({CARRYINSEL_OUT, INMODE_OUT, OPMODE_OUT, ALUMODE_OUT}), 32'(e.mode));
    chk("ce",   32'(CE_OUT), 32'(e.ce));
    chk("busy", 32'(BUSY),   32'(e.busy));
    chk("done", 32'(DONE),   32'(e.done));
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [19:0] w);
    cyc(mk(1'b0, 1'b1, a, w, 1'b0, '0, 1'b0, 1'b0, last_mode, 1'b0, 1'b0, 1'b0));
    shadow[a] = w;
  endtask

  // Expected timing: k slots per pass, issues on edges 1..k*p (stall edges
  // issue nothing), LATENCY drain edges, then the DONE edge.
  task automatic run_seq(input int k, input int passes, input int st_lo, input int st_hi,
                         input int we_at, input logic [19:0] we_word);
    int   issued  = 0;
    int   drained = 0;
    int   n_iss   = k * passes;
    logic stl, wen;
    cyc(mk(1'b0, 1'b0, '0, '0, 1'b1, CNTW'(passes - 1), 1'b0, 1'b0, last_mode,
           1'b0, 1'b0, 1'b0));
    for (int e = 1; e < 4000; e++) begin
      stl = (e >= st_lo) && (e <= st_hi);
      wen = (e == we_at);
      if (issued < n_iss) begin
        if (!stl) begin
          last_mode = shadow[issued % k][18:0];
          issued++;
        end
        cyc(mk(1'b0, wen, '0, we_word, 1'b0, '0, stl, 1'b0, last_mode, !stl, 1'b1, 1'b0));
      end else if (drained < LATENCY) begin
        if (!stl) drained++;
        cyc(mk(1'b0, wen, '0, we_word, 1'b0, '0, stl, 1'b0, last_mode, !stl, 1'b1, 1'b0));
      end else begin
        cyc(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, last_mode, 1'b0, 1'b0, 1'b1));
        break;
      end
    end
    cyc(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, last_mode, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [19:0] wa[3];
    logic [19:0] neww;
    logic [18:0] m0, m1, m2;

    wa[0] = mkw(1'b0, 4'd0, 0);
    wa[1] = mkw(1'b0, 4'd3, 1);
    wa[2] = mkw(1'b1, 4'd1, 2);
    m0 = wa[0][18:0];
    m1 = wa[1][18:0];
    m2 = wa[2][18:0];

    // Run A: REPS=1, 3 slots, no stall. Run B: same with STALL on edges 3..4.
    tbl[0]  = row(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = row(1'b0, 1'b0, m0, 1'b1, 1'b1, 1'b0);
    tbl[2]  = row(1'b0, 1'b0, m1, 1'b1, 1'b1, 1'b0);
    tbl[3]  = row(1'b0, 1'b0, m2, 1'b1, 1'b1, 1'b0);
    tbl[4]  = row(1'b0, 1'b0, m0, 1'b1, 1'b1, 1'b0);
    tbl[5]  = row(1'b0, 1'b0, m1, 1'b1, 1'b1, 1'b0);
    tbl[6]  = row(1'b0, 1'b0, m2, 1'b1, 1'b1, 1'b0);
    for (int unsigned i = 7; i <= 10; i++) tbl[i] = row(1'b0, 1'b0, m2, 1'b1, 1'b1, 1'b0);
    tbl[11] = row(1'b0, 1'b0, m2, 1'b0, 1'b0, 1'b1);
    tbl[12] = row(1'b0, 1'b0, m2, 1'b0, 1'b0, 1'b0);
    tbl[13] = row(1'b1, 1'b0, m2, 1'b0, 1'b0, 1'b0);
    tbl[14] = row(1'b0, 1'b0, m0, 1'b1, 1'b1, 1'b0);
    tbl[15] = row(1'b0, 1'b0, m1, 1'b1, 1'b1, 1'b0);
    tbl[16] = row(1'b0, 1'b1, m1, 1'b0, 1'b1, 1'b0);
    tbl[17] = row(1'b0, 1'b1, m1, 1'b0, 1'b1, 1'b0);
    tbl[18] = row(1'b0, 1'b0, m2, 1'b1, 1'b1, 1'b0);
    tbl[19] = row(1'b0, 1'b0, m0, 1'b1, 1'b1, 1'b0);
    tbl[20] = row(1'b0, 1'b0, m1, 1'b1, 1'b1, 1'b0);
    tbl[21] = row(1'b0, 1'b0, m2, 1'b1, 1'b1, 1'b0);
    for (int unsigned i = 22; i <= 25; i++) tbl[i] = row(1'b0, 1'b0, m2, 1'b1, 1'b1, 1'b0);
    tbl[26] = row(1'b0, 1'b0, m2, 1'b0, 1'b0, 1'b1);
    tbl[27] = row(1'b0, 1'b0, m2, 1'b0, 1'b0, 1'b0);

    last_mode = '0;
    for (int unsigned i = 0; i < DEPTH; i++) shadow[i] = '0;

    phase = "reset";
    cyc(mk(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
    cyc(mk(1'b1, 1'b0, '0, '0, 1'b1, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0));

    phase = "prog";
    for (int unsigned i = 0; i < 3; i++) wr(AW'(i), wa[i]);

    phase = "table";
    for (int unsigned i = 0; i < 28; i++) cyc(tbl[i]);
    last_mode = m2;

    phase = "nolast";
    for (int unsigned i = 0; i < DEPTH; i++) wr(AW'(i), mkw(1'b0, 4'(i + 4), i));
    run_seq(8, 1, -1, -1, -1, '0);

    phase = "we_busy";
    run_seq(8, 1, 10, 11, 2, mkw(1'b0, 4'hF, 9));
    run_seq(8, 1, -1, -1, -1, '0);

    phase = "we_start";
    neww = mkw(1'b0, 4'hE, 5);
    cyc(mk(1'b0, 1'b1, '0, neww, 1'b1, '0, 1'b0, 1'b0, last_mode, 1'b0, 1'b0, 1'b0));
    shadow[0] = neww;
    cyc(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, last_mode, 1'b0, 1'b0, 1'b0));
    run_seq(8, 1, -1, -1, -1, '0);

    phase = "midreset";
    cyc(mk(1'b0, 1'b0, '0, '0, 1'b1, '0, 1'b0, 1'b0, last_mode, 1'b0, 1'b0, 1'b0));
    cyc(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, shadow[0][18:0], 1'b1, 1'b1, 1'b0));
    cyc(mk(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
    last_mode = '0;
    for (int unsigned i = 0; i < 6; i++)
      cyc(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
    run_seq(8, 1, -1, -1, -1, '0);

    phase = "two_pass";
    run_seq(8, 2, 3, 3, -1, '0);

    phase = "reps_max";
    wr('0, mkw(1'b1, 4'hA, 0));
    run_seq(1, 256, -1, -1, -1, '0);

`ifdef DSP_SEQ_ABORT_EN
    phase = "abort";
    cyc(mk(1'b0, 1'b0, '0, '0, 1'b1, '0, 1'b0, 1'b0, last_mode, 1'b0, 1'b0, 1'b0));
    last_mode = shadow[0][18:0];
    cyc(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, last_mode, 1'b1, 1'b1, 1'b0));
    cyc(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, last_mode, 1'b1, 1'b1, 1'b0));
    cyc(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, last_mode, 1'b0, 1'b1, 1'b0));
    cyc(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, last_mode, 1'b0, 1'b0, 1'b1));
    cyc(mk(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, last_mode, 1'b0, 1'b0, 1'b0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
